// File: rtl/vrf_bank_arbiter_pkg.sv
// Shared types, sizes and address-mapping helpers for the VRF bank arbiter.
package vrf_bank_arbiter_pkg;

  localparam int unsigned NrOpQueue          = 3;
  localparam int unsigned NrWriteBackVFU     = 2;
  localparam int unsigned NrBank             = 8;
  localparam int unsigned VrfAddrW           = 8;
  localparam int unsigned VrfDataW           = 64;
  localparam int unsigned VrfStrbW           = VrfDataW / 8;
  localparam int unsigned BankIdW            = $clog2(NrBank);
  localparam int unsigned BankAddrW          = VrfAddrW - BankIdW;
  localparam int unsigned DefaultStarveLimit = 4;

  typedef logic [VrfAddrW-1:0]  vrf_addr_t;
  typedef logic [VrfDataW-1:0]  vrf_data_t;
  typedef logic [VrfStrbW-1:0]  vrf_strb_t;
  typedef logic [BankIdW-1:0]   bank_id_t;
  typedef logic [BankAddrW-1:0] bank_addr_t;

  // Read requesters (operand queues) and write requesters (write-back VFUs).
  typedef enum logic [1:0] {
    ALU_A    = 2'd0,
    ALU_B    = 2'd1,
    STORE_OP = 2'd2
  } op_queue_e;

  typedef enum logic {
    WB_VALU = 1'b0,
    WB_VLU  = 1'b1
  } wb_vfu_e;

  // Low address bits select the bank so consecutive words stripe across banks.
  function automatic bank_id_t GetBankId(vrf_addr_t addr);
    return addr[BankIdW-1:0];
  endfunction

  // Remaining upper bits address the word inside the selected bank.
  function automatic bank_addr_t GetBankAddr(vrf_addr_t addr);
    return addr[VrfAddrW-1:BankIdW];
  endfunction

endpackage

// File: rtl/vrf_bank_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr_i wins.
// Reports the one-hot grant, the winner index and the pointer to use next.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic [PtrW-1:0] next_ptr_o,
  output logic            valid_o
);

  // Scan the requesters starting from the pointer and take the first one found.
  always_comb begin
    int unsigned cand;
    // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr_i + i;
      if (cand >= N) cand = cand - N;
      if (!valid_o && req_i[cand[PtrW-1:0]]) begin
        valid_o                 = 1'b1;
        gnt_o[cand[PtrW-1:0]]   = 1'b1;
        idx_o                   = cand[PtrW-1:0];
      end
    end
  end

  // Winner + 1, wrapping at N.
  assign next_ptr_o = (idx_o == PtrW'(N - 1)) ? '0 : idx_o + 1'b1;

endmodule

// File: rtl/vrf_bank_arbiter.sv
// Per-lane arbiter for the single-ported VRF banks: write-back has priority,
// readers denied StarveLimit cycles in a row outrank writers, and bank read data
// is steered back to its operand queue one cycle after the grant.
// Optional: define VRF_BANK_CONFLICT_CNT_EN to add conflict_cnt_o.
module vrf_bank_arbiter
  import vrf_bank_arbiter_pkg::*;
#(
  parameter int unsigned NrRd        = NrOpQueue,
  parameter int unsigned NrWr        = NrWriteBackVFU,
  parameter int unsigned StarveLimit = DefaultStarveLimit
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic      [NrRd-1:0]     rd_valid_i,
  input  vrf_addr_t [NrRd-1:0]     rd_addr_i,
  output logic      [NrRd-1:0]     rd_ready_o,
  output logic      [NrRd-1:0]     rd_rvalid_o,
  output vrf_data_t [NrRd-1:0]     rd_rdata_o,
  input  logic      [NrWr-1:0]     wr_valid_i,
  input  vrf_addr_t [NrWr-1:0]     wr_addr_i,
  input  vrf_data_t [NrWr-1:0]     wr_data_i,
  input  vrf_strb_t [NrWr-1:0]     wr_strb_i,
  output logic      [NrWr-1:0]     wr_ready_o,
  output logic       [NrBank-1:0]  bank_req_o,
  output logic       [NrBank-1:0]  bank_we_o,
  output bank_addr_t [NrBank-1:0]  bank_addr_o,
  output vrf_data_t  [NrBank-1:0]  bank_wdata_o,
  output vrf_strb_t  [NrBank-1:0]  bank_strb_o,
  input  vrf_data_t  [NrBank-1:0]  bank_rdata_i
`ifdef VRF_BANK_CONFLICT_CNT_EN
  ,
  output logic [31:0]              conflict_cnt_o
`endif
);

  localparam int unsigned RdPtrW  = (NrRd > 1) ? $clog2(NrRd) : 1;
  localparam int unsigned WrPtrW  = (NrWr > 1) ? $clog2(NrWr) : 1;
  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  logic                                rst_q;
  logic                                blocked;
  logic [NrRd-1:0][StarveW-1:0]        starve_cnt_q;
  logic [NrRd-1:0]                     rd_starve;
  logic [NrBank-1:0][RdPtrW-1:0]       rd_ptr_q, rd_next_ptr, rd_idx, owner_q;
  logic [NrBank-1:0][WrPtrW-1:0]       wr_ptr_q, wr_next_ptr, wr_idx;
  logic [NrBank-1:0][NrRd-1:0]         rd_cand, rd_req, rd_gnt;
  logic [NrBank-1:0][NrWr-1:0]         wr_cand, wr_gnt;
  logic [NrBank-1:0]                   rd_any, wr_any, use_rd, use_wr, own_v_q;

  // Nothing is granted while reset is held or on the first cycle after it.
  assign blocked = rst_i | rst_q;

  for (genvar r = 0; r < NrRd; r++) begin : g_starve
    assign rd_starve[r] = (starve_cnt_q[r] >= StarveW'(StarveLimit));
  end

  for (genvar b = 0; b < NrBank; b++) begin : g_bank
    logic [NrRd-1:0] rd_starved;

    for (genvar r = 0; r < NrRd; r++) begin : g_rd_cand
      assign rd_cand[b][r] = rd_valid_i[r] && (GetBankId(rd_addr_i[r]) == bank_id_t'(b));
    end
    for (genvar w = 0; w < NrWr; w++) begin : g_wr_cand
      assign wr_cand[b][w] = wr_valid_i[w] && (GetBankId(wr_addr_i[w]) == bank_id_t'(b));
    end

    // Starved readers restrict the read pick to themselves.
    assign rd_starved = rd_cand[b] & rd_starve;
    assign rd_req[b]  = (|rd_starved) ? rd_starved : rd_cand[b];

    rr_arbiter #(.N(NrRd)) u_rd_arb (
      .req_i      (rd_req[b]),
      .ptr_i      (rd_ptr_q[b]),
      .gnt_o      (rd_gnt[b]),
      .idx_o      (rd_idx[b]),
      .next_ptr_o (rd_next_ptr[b]),
      .valid_o    (rd_any[b])
    );

    rr_arbiter #(.N(NrWr)) u_wr_arb (
      .req_i      (wr_cand[b]),
      .ptr_i      (wr_ptr_q[b]),
      .gnt_o      (wr_gnt[b]),
      .idx_o      (wr_idx[b]),
      .next_ptr_o (wr_next_ptr[b]),
      .valid_o    (wr_any[b])
    );

    // Starved read > write > ordinary read.
    assign use_rd[b] = ~blocked & rd_any[b] & ((|rd_starved) | ~wr_any[b]);
    assign use_wr[b] = ~blocked & wr_any[b] & ~(|rd_starved);
  end

  // Fold per-bank grants into per-requester ready.
  always_comb begin
    rd_ready_o = '0;
    wr_ready_o = '0;
    for (int b = 0; b < NrBank; b++) begin
      rd_ready_o = rd_ready_o | (rd_gnt[b] & {NrRd{use_rd[b]}});
      wr_ready_o = wr_ready_o | (wr_gnt[b] & {NrWr{use_wr[b]}});
    end
  end

  // Drive each bank from its winner; idle banks output zeros.
  always_comb begin
    bank_req_o   = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    bank_strb_o  = '0;
    for (int b = 0; b < NrBank; b++) begin
      bank_req_o[b] = use_rd[b] | use_wr[b];
      bank_we_o[b]  = use_wr[b];
      if (use_wr[b]) begin
        bank_addr_o[b]  = GetBankAddr(wr_addr_i[wr_idx[b]]);
        bank_wdata_o[b] = wr_data_i[wr_idx[b]];
        bank_strb_o[b]  = wr_strb_i[wr_idx[b]];
      end else if (use_rd[b]) begin
        bank_addr_o[b]  = GetBankAddr(rd_addr_i[rd_idx[b]]);
      end
    end
  end

  // Steer last cycle's bank read data to the reader that owns each bank.
  always_comb begin
    rd_rvalid_o = '0;
    rd_rdata_o  = '0;
    for (int b = 0; b < NrBank; b++) begin
      for (int r = 0; r < NrRd; r++) begin
        if (!blocked && own_v_q[b] && (owner_q[b] == RdPtrW'(r))) begin
          rd_rvalid_o[r] = 1'b1;
          rd_rdata_o[r]  = bank_rdata_i[b];
        end
      end
    end
  end

  // Delayed reset flag that masks grants on the cycle after reset.
  always_ff @(posedge clk_i) begin
    // NOTE: rst_q has no reset of its own; it simply follows rst_i one cycle late.
    rst_q <= rst_i;
  end

  // Pointers, read ownership and starvation counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      owner_q      <= '0;
      own_v_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      for (int b = 0; b < NrBank; b++) begin
        if (use_rd[b]) rd_ptr_q[b] <= rd_next_ptr[b];
        if (use_wr[b]) wr_ptr_q[b] <= wr_next_ptr[b];
        own_v_q[b] <= use_rd[b];
        if (use_rd[b]) owner_q[b] <= rd_idx[b];
      end
      for (int r = 0; r < NrRd; r++) begin
        if (rd_valid_i[r] && !rd_ready_o[r]) begin
          if (starve_cnt_q[r] != StarveW'(StarveLimit)) starve_cnt_q[r] <= starve_cnt_q[r] + 1'b1;
        end else begin
          starve_cnt_q[r] <= '0;
        end
      end
    end
  end

`ifdef VRF_BANK_CONFLICT_CNT_EN
  logic conflict;
  assign conflict = (|(rd_valid_i & ~rd_ready_o)) | (|(wr_valid_i & ~wr_ready_o));

  // Saturating count of cycles with at least one denied requester.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
    end else if (conflict && (conflict_cnt_o != '1)) begin
      conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// Directed bench for vrf_bank_arbiter with a small strobe-aware bank memory model.
module tb_vrf_bank_arbiter;
  import vrf_bank_arbiter_pkg::*;

  localparam int unsigned BankWords = 1 << BankAddrW;

  logic                             clk_i = 1'b0;
  logic                             rst_i;
  logic       [NrOpQueue-1:0]       rd_valid;
  vrf_addr_t  [NrOpQueue-1:0]       rd_addr;
  logic       [NrOpQueue-1:0]       rd_ready, rd_rvalid;
  vrf_data_t  [NrOpQueue-1:0]       rd_rdata;
  logic       [NrWriteBackVFU-1:0]  wr_valid, wr_ready;
  vrf_addr_t  [NrWriteBackVFU-1:0]  wr_addr;
  vrf_data_t  [NrWriteBackVFU-1:0]  wr_data;
  vrf_strb_t  [NrWriteBackVFU-1:0]  wr_strb;
  logic       [NrBank-1:0]          bank_req, bank_we;
  bank_addr_t [NrBank-1:0]          bank_addr;
  vrf_data_t  [NrBank-1:0]          bank_wdata, bank_rdata;
  vrf_strb_t  [NrBank-1:0]          bank_strb;
`ifdef VRF_BANK_CONFLICT_CNT_EN
  logic [31:0]                      conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  vrf_bank_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rd_valid_i   (rd_valid),
    .rd_addr_i    (rd_addr),
    .rd_ready_o   (rd_ready),
    .rd_rvalid_o  (rd_rvalid),
    .rd_rdata_o   (rd_rdata),
    .wr_valid_i   (wr_valid),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_strb_i    (wr_strb),
    .wr_ready_o   (wr_ready),
    .bank_req_o   (bank_req),
    .bank_we_o    (bank_we),
    .bank_addr_o  (bank_addr),
    .bank_wdata_o (bank_wdata),
    .bank_strb_o  (bank_strb),
    .bank_rdata_i (bank_rdata)
`ifdef VRF_BANK_CONFLICT_CNT_EN
    ,
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Recognisable initial contents: DA7A, bank, word, 0BADF00D.
  function automatic vrf_data_t init_word(int b, int a);
    return {16'hDA7A, 8'(b), 8'(a), 32'h0BAD_F00D};
  endfunction

  // Single-ported bank model: byte-strobed write or 1-cycle-latency read.
  vrf_data_t mem [NrBank][BankWords];
  always @(posedge clk_i) begin
    for (int b = 0; b < NrBank; b++) begin
      if (rst_i) begin
        for (int a = 0; a < BankWords; a++) mem[b][a] <= init_word(b, a);
        bank_rdata[b] <= '0;
      end else if (bank_req[b]) begin
        if (bank_we[b]) begin
          for (int k = 0; k < VrfStrbW; k++)
            if (bank_strb[b][k]) mem[b][bank_addr[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
        end else begin
          bank_rdata[b] <= mem[b][bank_addr[b]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i    = 1'b1;
    rd_valid = '0;
    rd_addr  = '0;
    wr_valid = '0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_strb  = '0;

    // Reset: a pending request must not be granted during or right after reset.
    rd_valid = 3'b001; rd_addr[ALU_A] = 8'h09;
    step(); #1;
    check("rst_rd_ready", 64'(rd_ready), 64'h0);
    check("rst_bank_req", 64'(bank_req), 64'h0);
`ifdef VRF_BANK_CONFLICT_CNT_EN
    check("rst_conflict_cnt", 64'(conflict_cnt), 64'h0);
`endif
    step(); rst_i = 1'b0; #1;
    check("post_rst_rd_ready", 64'(rd_ready), 64'h0);
    check("post_rst_bank_req", 64'(bank_req), 64'h0);
    check("post_rst_rvalid", 64'(rd_rvalid), 64'h0);
    step(); rd_valid = '0; #1;

    // Single read of 0x09: bank 1, word 1, data one cycle later.
    step(); rd_valid = 3'b001; rd_addr[ALU_A] = 8'h09; #1;
    check("t1_rd_ready", 64'(rd_ready), 64'h1);
    check("t1_bank_req", 64'(bank_req), 64'h02);
    check("t1_bank_we", 64'(bank_we), 64'h00);
    check("t1_bank_addr", 64'(bank_addr[1]), 64'h1);
    step(); rd_valid = '0; #1;
    check("t1_rvalid", 64'(rd_rvalid), 64'h1);
    check("t1_rdata", rd_rdata[ALU_A], 64'hDA7A_0101_0BAD_F00D);

    // Three readers on bank 2: served ALUA, ALUB, StoreOp, pointer back at 0.
    step();
    rd_valid = 3'b111;
    rd_addr[ALU_A] = 8'h02; rd_addr[ALU_B] = 8'h0A; rd_addr[STORE_OP] = 8'h12; #1;
    check("t2_c0_ready", 64'(rd_ready), 64'b001);
    step(); rd_valid = 3'b110; #1;
    check("t2_c1_ready", 64'(rd_ready), 64'b010);
    check("t2_c1_rvalid", 64'(rd_rvalid), 64'b001);
    check("t2_c1_rdata", rd_rdata[ALU_A], 64'hDA7A_0200_0BAD_F00D);
    step(); rd_valid = 3'b100; #1;
    check("t2_c2_ready", 64'(rd_ready), 64'b100);
    check("t2_c2_rvalid", 64'(rd_rvalid), 64'b010);
    check("t2_c2_rdata", rd_rdata[ALU_B], 64'hDA7A_0201_0BAD_F00D);
    step(); rd_valid = 3'b111; #1;
    check("t2_ptr_wrap_ready", 64'(rd_ready), 64'b001);
    check("t2_c3_rvalid", 64'(rd_rvalid), 64'b100);
    check("t2_c3_rdata", rd_rdata[STORE_OP], 64'hDA7A_0202_0BAD_F00D);
    step(); rd_valid = '0; #1;

    // Starvation: writer owns bank 3 for 4 cycles, then ALUA wins once.
    step();
    wr_valid = 2'b01; wr_addr[WB_VALU] = 8'h03;
    wr_data[WB_VALU] = 64'h1111_2222_3333_4444; wr_strb[WB_VALU] = 8'hFF;
    rd_valid = 3'b001; rd_addr[ALU_A] = 8'h0B;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_wr_win%0d", i), 64'({wr_ready, rd_ready}), 64'b01_000);
      step();
    end
    #1;
    check("t3_starved_rd_win", 64'({wr_ready, rd_ready}), 64'b00_001);
    step(); rd_valid = '0; #1;
    check("t3_wr_resume", 64'(wr_ready), 64'b01);
    check("t3_rdata", rd_rdata[ALU_A], 64'hDA7A_0301_0BAD_F00D);
    step(); wr_valid = '0; #1;

    // Two writers on bank 4 alternate.
    step();
    wr_valid = 2'b11; wr_addr[WB_VALU] = 8'h04; wr_addr[WB_VLU] = 8'h0C;
    wr_data[WB_VLU] = 64'h5555_6666_7777_8888; wr_strb[WB_VLU] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t4_alt%0d", i), 64'(wr_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
      step();
    end
    // Different banks in parallel: WB_VLU to bank 5, ALUA from bank 6.
    wr_valid = 2'b10; wr_addr[WB_VLU] = 8'h05;
    rd_valid = 3'b001; rd_addr[ALU_A] = 8'h06; #1;
    check("t4_par_ready", 64'({wr_ready, rd_ready}), 64'b10_001);
    check("t4_par_bank_req", 64'(bank_req), 64'h60);
    check("t4_par_bank_we", 64'(bank_we), 64'h20);
    step(); wr_valid = '0; rd_valid = '0; #1;
    check("t4_par_rdata", rd_rdata[ALU_A], 64'hDA7A_0600_0BAD_F00D);

    // Same-word read and write: write wins, retried read returns merged data.
    step();
    wr_valid = 2'b01; wr_addr[WB_VALU] = 8'h01;
    wr_data[WB_VALU] = '1; wr_strb[WB_VALU] = 8'h0F;
    rd_valid = 3'b001; rd_addr[ALU_A] = 8'h01; #1;
    check("t5_wr_first", 64'({wr_ready, rd_ready}), 64'b01_000);
    step(); wr_valid = '0; #1;
    check("t5_rd_retry", 64'(rd_ready), 64'b001);
    step(); rd_valid = '0; #1;
    check("t5_rvalid", 64'(rd_rvalid), 64'b001);
    check("t5_rdata", rd_rdata[ALU_A], 64'hDA7A_0100_FFFF_FFFF);

    // Reset right after a grant: return dropped, pointers cleared.
    step(); rd_valid = 3'b001; rd_addr[ALU_A] = 8'h09; #1;
    check("t6_pre_ready", 64'(rd_ready), 64'b001);
    step(); rst_i = 1'b1; rd_valid = '0; #1;
    check("t6_rst_rvalid", 64'(rd_rvalid), 64'h0);
    step(); rst_i = 1'b0;
    rd_valid = 3'b101; rd_addr[ALU_A] = 8'h09; rd_addr[STORE_OP] = 8'h11; #1;
    check("t6_post_rst_ready", 64'(rd_ready), 64'h0);
    check("t6_post_rst_rvalid", 64'(rd_rvalid), 64'h0);
`ifdef VRF_BANK_CONFLICT_CNT_EN
    check("t6_conflict_cnt_zero", 64'(conflict_cnt), 64'h0);
`endif
    step(); #1;
    check("t6_ptr_reset_ready", 64'(rd_ready), 64'b001);
`ifdef VRF_BANK_CONFLICT_CNT_EN
    check("t6_conflict_cnt_one", 64'(conflict_cnt), 64'h1);
`endif
    step(); rd_valid = 3'b100; #1;
    check("t6_so_ready", 64'(rd_ready), 64'b100);
    check("t6_alua_rdata", rd_rdata[ALU_A], 64'hDA7A_0101_0BAD_F00D);
    step(); rd_valid = '0; #1;
    check("t6_so_rdata", rd_rdata[STORE_OP], 64'hDA7A_0102_0BAD_F00D);
    check("idle_bank_req", 64'(bank_req), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
